// File: rtl/ram64_burst_reader_pkg.sv
// Shared definitions for the 64-entry RAM burst reader: pointer geometry and FSM encoding.
package ram64_burst_reader_pkg;

   localparam int PTR_W = 7;
   localparam int DEPTH = 64;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

endpackage

// File: rtl/ram64_burst_reader.sv
// Read-side controller for a 64-entry distributed RAM: tracks occupancy against the writer
// pointer, drains bursts onto a valid/ready stream and flushes partial bursts after a timeout.
//
//   state  | meaning
//   IDLE   | waiting for a full burst or for the idle timeout on a partial one
//   STREAM | popping len words; the pop with burst_cnt == len-1 carries m_last
module ram64_burst_reader
   import ram64_burst_reader_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int BURST = 16,
   parameter int TMO_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [5:0]       ram_raddr,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   input  logic [TMO_W-1:0] cfg_tmo,
   input  logic             flush,
   output logic [PTR_W-1:0] level,
   output logic             ovf_err
);

   localparam logic [PTR_W-1:0] BURST_L = PTR_W'(BURST);
   localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);

   rd_state_t        state, state_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic [PTR_W-1:0] burst_cnt, bcnt_nxt;
   logic [PTR_W-1:0] len, len_nxt;
   logic             pop, last_pop;

   // Level is modular on purpose: an overrun still drains using the wrapped difference.
   assign level     = wr_ptr - rd_ptr;
   assign ram_raddr = rd_ptr[5:0];
   assign pop       = (state == STREAM) && (level != '0) && (!m_valid || m_ready);
   assign last_pop  = pop && (burst_cnt == len - PTR_W'(1));

   always_comb begin
      state_nxt = state;
      tmo_nxt   = tmo_cnt;
      bcnt_nxt  = burst_cnt;
      len_nxt   = len;
      if (flush) begin
         state_nxt = IDLE;
         tmo_nxt   = '0;
         bcnt_nxt  = '0;
         len_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               bcnt_nxt = '0;
               if (level >= BURST_L) begin
                  state_nxt = STREAM;
                  len_nxt   = BURST_L;
                  tmo_nxt   = '0;
               end else if (level != '0) begin
                  if ((cfg_tmo != '0) && (tmo_cnt == cfg_tmo - TMO_W'(1))) begin
                     state_nxt = STREAM;
                     len_nxt   = level;
                     tmo_nxt   = '0;
                  end else begin
                     tmo_nxt = tmo_cnt + TMO_W'(1);
                  end
               end else begin
                  tmo_nxt = '0;
               end
            end
            STREAM: begin
               tmo_nxt = '0;
               if (last_pop) begin
                  state_nxt = IDLE;
                  bcnt_nxt  = '0;
               end else if (pop) begin
                  bcnt_nxt = burst_cnt + PTR_W'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         burst_cnt <= '0;
         len       <= '0;
      end else begin
         state     <= state_nxt;
         tmo_cnt   <= tmo_nxt;
         burst_cnt <= bcnt_nxt;
         len       <= len_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if (level > DEPTH_L)
            ovf_err <= 1'b1;
         if (flush) begin
            rd_ptr  <= wr_ptr;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end else if (pop) begin
            m_data  <= ram_rdata;
            m_valid <= 1'b1;
            m_last  <= last_pop;
            rd_ptr  <= rd_ptr + PTR_W'(1);
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

endmodule
